sum_accumulator: RTL and testbench
==================================

SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 Parameter N, default 16: width of the input sum beat. Each beat is the Sum output of the 16-bit carry-propagate adder, so it carries no carry-out.
REQ-002 Parameter ACC_W, default 24: accumulator width; ACC_W SHALL be greater than N.
REQ-003 Parameter CNT_W, default 8: beat-counter width.
REQ-004 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  in_sum and in_last are valid this cycle.
REQ-007 in_ready  output  1  block can accept a beat this cycle.
REQ-008 in_sum  input  N  unsigned adder result to accumulate.
REQ-009 in_last  input  1  marks the final beat of a frame.
REQ-010 out_valid  output  1  frame result is presented.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 out_acc  output  ACC_W  unsigned sum of the frame's beats, modulo 2^ACC_W.
REQ-013 out_count  output  CNT_W  number of beats in the frame, saturating.
REQ-014 out_ovf  output  1  sticky per frame: accumulator wrap or count saturation occurred.

Function
REQ-015 The block SHALL implement a three-state FSM: IDLE, ACCUM, HOLD.
REQ-016 A beat is accepted on a clock edge where in_valid=1 and in_ready=1.
REQ-017 in_ready SHALL be 1 in IDLE and ACCUM, and 0 in HOLD; it SHALL be a registered function of state and SHALL NOT depend combinationally on out_ready.
REQ-018 IDLE, on an accepted beat: acc := zero-extended in_sum; count := 1; ovf := 0. Next state is HOLD if in_last=1, else ACCUM.
REQ-019 ACCUM, on an accepted beat: acc := acc + zero-extended in_sum, modulo 2^ACC_W. Next state is HOLD if in_last=1, else ACCUM.
REQ-020 A carry out of bit ACC_W-1 in REQ-019 SHALL set ovf.
REQ-021 count SHALL increment on each accepted beat and saturate at 2^CNT_W-1; an accept made while count is already 2^CNT_W-1 SHALL set ovf.
REQ-022 With no accepted beat, acc, count, ovf and state SHALL hold.
REQ-023 Latency: if the last beat is accepted at edge t, out_valid=1 SHALL be seen after edge t, and out_acc/out_count/out_ovf SHALL include that beat.
REQ-024 In HOLD: out_valid=1, and out_acc/out_count/out_ovf SHALL be stable until the handshake.
REQ-025 On out_valid=1 and out_ready=1, the next state SHALL be IDLE.
REQ-026 Outside HOLD, out_valid SHALL be 0 and out_* SHALL hold the last frame's values.
REQ-027 One-beat frame: a beat with in_last=1 accepted in IDLE SHALL give out_count=1 and out_acc=in_sum.
REQ-028 Input while in HOLD: in_valid is ignored and no beat is lost; the source holds the beat under the valid/ready rule.
REQ-029 The minimum frame-to-frame gap SHALL be one cycle (the IDLE cycle after the output handshake).
REQ-030 Once in_valid=1, the upstream SHALL keep in_valid, in_sum and in_last stable until accepted; the block need not detect violations.

Reset
REQ-031 rst_n=0 SHALL immediately, without waiting for clk, force state=IDLE, acc=0, count=0, ovf=0, out_valid=0, out_acc=0, out_count=0, out_ovf=0.
REQ-032 rst_n=0 SHALL force in_ready=1.
REQ-033 Reset in mid-frame or in HOLD SHALL discard the partial or pending result with no output handshake.
REQ-034 After rst_n deasserts, the first accepted beat SHALL start a new frame.

Verification
REQ-035 Four-beat frame 0x0001, 0x0002, 0x0003, 0x0004 (last), out_ready=1 -> out_acc=0x00000A, out_count=4, out_ovf=0, out_valid for exactly 1 cycle.
REQ-036 Backpressure: out_ready=0 for 5 cycles after a frame ends -> out_valid held, out_* stable, in_ready=0 throughout; then out_ready=1 -> IDLE on the next edge, in_ready=1.
REQ-037 Accumulator wrap with ACC_W=17: beats 0xFFFF, 0xFFFF (last) -> out_acc=0x1FFFE, out_ovf=0. A third 0xFFFF in the frame -> out_acc=0x0FFFD, out_ovf=1.
REQ-038 Count saturation, CNT_W=2: five beats of 0x0001, last on the fifth -> out_count=3, out_ovf=1, out_acc=5.
REQ-039 rst_n pulsed low after 2 beats of a frame -> all outputs 0 without waiting for a clock edge. A new 1-beat frame of 0x1234 (last) -> out_acc=0x001234, out_count=1.
REQ-040 Back-to-back one-beat frames 0x0010 then 0x0020, in_valid held high, out_ready=1 -> two results, 0x000010 then 0x000020, with exactly 1 idle cycle between accepts.

Source files
------------

// File: rtl/sum_accumulator.sv
// Frame accumulator: sums unsigned adder beats until in_last, then holds the
// frame total, beat count and overflow flag until the downstream handshake.
module sum_accumulator #(
    parameter int N     = 16,
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_sum,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] out_acc_q, out_acc_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic             out_ovf_q, out_ovf_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;

    logic             accept;
    logic [ACC_W:0]   sum_ext;

    assign accept  = in_valid && in_ready_q;
    assign sum_ext = {1'b0, acc_q} + {{(ACC_W + 1 - N){1'b0}}, in_sum};

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        out_acc_d = out_acc_q;
        out_cnt_d = out_cnt_q;
        out_ovf_d = out_ovf_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d   = {{(ACC_W - N){1'b0}}, in_sum};
                    cnt_d   = CNT_W'(1);
                    ovf_d   = 1'b0;
                    state_d = in_last ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_d   = sum_ext[ACC_W-1:0];
                    ovf_d   = ovf_q | sum_ext[ACC_W] | (cnt_q == CNT_MAX);
                    cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                    state_d = in_last ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Result registers load on the closing beat so they include it and
        // stay frozen while the next frame accumulates.
        if (accept && in_last) begin
            out_acc_d = acc_d;
            out_cnt_d = cnt_d;
            out_ovf_d = ovf_d;
        end

        out_valid_d = (state_d == HOLD);
        in_ready_d  = (state_d != HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_acc_q   <= '0;
            out_cnt_q   <= '0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_acc_q   <= out_acc_d;
            out_cnt_q   <= out_cnt_d;
            out_ovf_q   <= out_ovf_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_acc   = out_acc_q;
    assign out_count = out_cnt_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Bench for sum_accumulator: a default-width instance and a narrow
// (ACC_W=17, CNT_W=2) instance share stimulus and are checked against a frame model.
module tb_sum_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] in_sum = '0;

    logic        b_in_ready, b_out_valid, b_out_ovf;
    logic [23:0] b_out_acc;
    logic [7:0]  b_out_count;
    logic        s_in_ready, s_out_valid, s_out_ovf;
    logic [16:0] s_out_acc;
    logic [1:0]  s_out_count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] beats[$];
    logic [23:0] eb_acc;
    logic [7:0]  eb_cnt;
    logic        eb_ovf;
    logic [16:0] es_acc;
    logic [1:0]  es_cnt;
    logic        es_ovf;

    sum_accumulator #(.N(16), .ACC_W(24), .CNT_W(8)) u_big (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_sum(in_sum), .in_last(in_last), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_acc(b_out_acc), .out_count(b_out_count),
        .out_ovf(b_out_ovf)
    );

    sum_accumulator #(.N(16), .ACC_W(17), .CNT_W(2)) u_small (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_sum(in_sum), .in_last(in_last), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_acc(s_out_acc), .out_count(s_out_count),
        .out_ovf(s_out_ovf)
    );

    always #5 clk = ~clk;

    // Frame model: true (unbounded) sum and beat count, reduced to each width.
    task automatic model_frame();
        longint unsigned total = 0;
        int nb = 0;
        foreach (beats[i]) begin
            total += 64'(beats[i]);
            nb++;
        end
        eb_acc = 24'(total);
        eb_cnt = (nb > 255) ? 8'd255 : 8'(nb);
        eb_ovf = (total >= (64'd1 << 24)) || (nb > 255);
        es_acc = 17'(total);
        es_cnt = (nb > 3) ? 2'd3 : 2'(nb);
        es_ovf = (total >= (64'd1 << 17)) || (nb > 3);
    endtask

    // Sends the queued beats; holds out_ready low for 'hold' cycles once the
    // frame result appears. With 'pend', a new beat is offered during HOLD.
    task automatic do_frame(input int hold, input bit pend);
        bit rdy;
        int waits;
        model_frame();
        out_ready = (hold == 0);
        foreach (beats[i]) begin
            in_valid = 1'b1;
            in_sum   = beats[i];
            in_last  = (i == beats.size() - 1);
            waits = 0;
            do begin
                @(negedge clk);
                rdy = b_in_ready;
                @(posedge clk);
                #1;
                waits++;
            end while (!rdy && waits < 20);
            n_cmp++;
            if (!rdy) begin
                n_bad++;
                $display("FAIL accept_timeout beat %0d: in_ready=%b required 1", i, rdy);
            end
        end
        if (pend) begin
            in_sum  = 16'h0055;
            in_last = 1'b1;
        end else begin
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
        n_cmp++;
        if ({b_out_valid, s_out_valid, b_in_ready, s_in_ready} !== 4'b1100) begin
            n_bad++;
            $display("FAIL result_flags: valid/ready=%b required 1100",
                     {b_out_valid, s_out_valid, b_in_ready, s_in_ready});
        end
        n_cmp++;
        if ({b_out_acc, b_out_count, b_out_ovf} !== {eb_acc, eb_cnt, eb_ovf}) begin
            n_bad++;
            $display("FAIL big_result: acc=%h cnt=%0d ovf=%b required acc=%h cnt=%0d ovf=%b",
                     b_out_acc, b_out_count, b_out_ovf, eb_acc, eb_cnt, eb_ovf);
        end
        n_cmp++;
        if ({s_out_acc, s_out_count, s_out_ovf} !== {es_acc, es_cnt, es_ovf}) begin
            n_bad++;
            $display("FAIL small_result: acc=%h cnt=%0d ovf=%b required acc=%h cnt=%0d ovf=%b",
                     s_out_acc, s_out_count, s_out_ovf, es_acc, es_cnt, es_ovf);
        end
        repeat (hold) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if ({b_out_valid, b_in_ready, s_in_ready} !== 3'b100 ||
                {b_out_acc, b_out_count, b_out_ovf} !== {eb_acc, eb_cnt, eb_ovf} ||
                {s_out_acc, s_out_count, s_out_ovf} !== {es_acc, es_cnt, es_ovf}) begin
                n_bad++;
                $display("FAIL hold_stable: valid=%b ready=%b acc=%h/%h required 1 0 %h/%h",
                         b_out_valid, b_in_ready, b_out_acc, s_out_acc, eb_acc, es_acc);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({b_out_valid, s_out_valid, b_in_ready, s_in_ready} !== 4'b0011 ||
            b_out_acc !== eb_acc || s_out_acc !== es_acc) begin
            n_bad++;
            $display("FAIL release: valid/ready=%b acc=%h/%h required 0011 %h/%h",
                     {b_out_valid, s_out_valid, b_in_ready, s_in_ready},
                     b_out_acc, s_out_acc, eb_acc, es_acc);
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        n_cmp++;
        if ({b_out_valid, b_out_acc, b_out_count, b_out_ovf, b_in_ready} !== {1'b0, 24'h0, 8'h0, 1'b0, 1'b1} ||
            {s_out_valid, s_out_acc, s_out_count, s_out_ovf, s_in_ready} !== {1'b0, 17'h0, 2'h0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_state: valid=%b acc=%h cnt=%0d ovf=%b ready=%b required 0 0 0 0 1",
                     b_out_valid, b_out_acc, b_out_count, b_out_ovf, b_in_ready);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_four_beat();
        beats = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
        do_frame(0, 1'b0);
        n_cmp++;
        if ({b_out_acc, b_out_count, b_out_ovf} !== {24'h00000A, 8'd4, 1'b0}) begin
            n_bad++;
            $display("FAIL four_beat: acc=%h cnt=%0d ovf=%b required 00000a 4 0",
                     b_out_acc, b_out_count, b_out_ovf);
        end
    endtask

    task automatic test_backpressure();
        beats = '{16'h0100, 16'h0200};
        do_frame(5, 1'b1);
        // The beat offered during HOLD is taken on the IDLE cycle that follows.
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        n_cmp++;
        if ({b_out_valid, b_out_acc, b_out_count, b_out_ovf} !== {1'b1, 24'h000055, 8'd1, 1'b0}) begin
            n_bad++;
            $display("FAIL held_beat: valid=%b acc=%h cnt=%0d ovf=%b required 1 000055 1 0",
                     b_out_valid, b_out_acc, b_out_count, b_out_ovf);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_wrap();
        beats = '{16'hFFFF, 16'hFFFF};
        do_frame(0, 1'b0);
        n_cmp++;
        if ({s_out_acc, s_out_ovf} !== {17'h1FFFE, 1'b0}) begin
            n_bad++;
            $display("FAIL wrap_two: acc=%h ovf=%b required 1fffe 0", s_out_acc, s_out_ovf);
        end
        beats = '{16'hFFFF, 16'hFFFF, 16'hFFFF};
        do_frame(1, 1'b0);
        n_cmp++;
        if ({s_out_acc, s_out_ovf} !== {17'h0FFFD, 1'b1}) begin
            n_bad++;
            $display("FAIL wrap_three: acc=%h ovf=%b required 0fffd 1", s_out_acc, s_out_ovf);
        end
    endtask

    task automatic test_saturation();
        beats = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001};
        do_frame(0, 1'b0);
        n_cmp++;
        if ({s_out_count, s_out_ovf, s_out_acc} !== {2'd3, 1'b1, 17'd5}) begin
            n_bad++;
            $display("FAIL saturation: cnt=%0d ovf=%b acc=%h required 3 1 00005",
                     s_out_count, s_out_ovf, s_out_acc);
        end
    endtask

    task automatic test_reset_midframe();
        in_valid = 1'b1;
        in_sum   = 16'h0100;
        in_last  = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({b_out_valid, b_out_acc, b_out_count, b_out_ovf, b_in_ready} !== {1'b0, 24'h0, 8'h0, 1'b0, 1'b1} ||
            {s_out_acc, s_out_count, s_out_ovf} !== {17'h0, 2'h0, 1'b0}) begin
            n_bad++;
            $display("FAIL async_reset: valid=%b acc=%h cnt=%0d ovf=%b ready=%b required 0 0 0 0 1",
                     b_out_valid, b_out_acc, b_out_count, b_out_ovf, b_in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (b_out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL no_stale_output: out_valid=%b required 0", b_out_valid);
        end
        beats = '{16'h1234};
        do_frame(0, 1'b0);
        n_cmp++;
        if ({b_out_acc, b_out_count} !== {24'h001234, 8'd1}) begin
            n_bad++;
            $display("FAIL post_reset_frame: acc=%h cnt=%0d required 001234 1", b_out_acc, b_out_count);
        end
    endtask

    task automatic test_back_to_back();
        bit rdy;
        int acc_edge[$];
        logic [23:0] res[$];
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_sum    = 16'h0010;
        in_last   = 1'b1;
        for (int e = 0; e < 10 && acc_edge.size() < 2; e++) begin
            @(negedge clk);
            rdy = b_in_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                acc_edge.push_back(e);
                in_sum = 16'h0020;
                if (acc_edge.size() == 2) in_valid = 1'b0;
            end
            if (b_out_valid) res.push_back(b_out_acc);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        n_cmp++;
        if (acc_edge.size() != 2 || acc_edge[1] - acc_edge[0] != 2) begin
            n_bad++;
            $display("FAIL b2b_gap: accepts=%0d spacing=%0d required 2 2", acc_edge.size(),
                     (acc_edge.size() == 2) ? acc_edge[1] - acc_edge[0] : -1);
        end
        n_cmp++;
        if (res.size() != 2 || res[0] !== 24'h000010 || res[1] !== 24'h000020) begin
            n_bad++;
            $display("FAIL b2b_results: count=%0d first=%h second=%h required 2 000010 000020",
                     res.size(), (res.size() > 0) ? res[0] : 24'hx, (res.size() > 1) ? res[1] : 24'hx);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        int nb;
        for (int f = 0; f < 25; f++) begin
            beats.delete();
            nb = $urandom_range(1, 7);
            for (int k = 0; k < nb; k++)
                beats.push_back(($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 15))
                                                             : 16'($urandom));
            do_frame($urandom_range(0, 3), 1'b0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_four_beat();
        test_backpressure();
        test_wrap();
        test_saturation();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
